// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants for the pipeline stall/flush controller.
//            Holds the flush-sequencer state encoding and the width and
//            saturation value of the source-stall performance counter.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Flush-sequencer state encoding
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  // Source-stall performance counter
  localparam int                     STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

  // Flush cycle counter width (FLUSH_CYCLES is at most 15)
  localparam int FLUSH_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Handshake bundle between the pipeline stages and the central
//            stall/flush controller.
//   i_stage_valid     : valid flag of each stage's output register
//   i_stage_stall_req : internal stall condition of each stage
//   i_sink_ready      : consumer after the last stage can accept
//   o_stage_stall     : stall to each stage
//   o_stage_ce        : per-stage clock enable
//   master modport = pipeline side, slave modport = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 4
);
  logic [NUM_STAGES-1:0] i_stage_valid;
  logic [NUM_STAGES-1:0] i_stage_stall_req;
  logic                  i_sink_ready;
  logic [NUM_STAGES-1:0] o_stage_stall;
  logic [NUM_STAGES-1:0] o_stage_ce;

  modport master (
    output i_stage_valid,
    output i_stage_stall_req,
    output i_sink_ready,
    input  o_stage_stall,
    input  o_stage_ce
  );

  modport slave (
    input  i_stage_valid,
    input  i_stage_stall_req,
    input  i_sink_ready,
    output o_stage_stall,
    output o_stage_ce
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_chain
// Purpose  : Purely combinational backward stall chain and per-stage clock
//            enable generator.
//   i_valid      : valid flag of each stage's output register
//   i_stall_req  : internal stall request of each stage
//   i_sink_ready : consumer after the last stage can accept
//   i_flush      : active flush mask (forces ce low)
//   o_stall      : stall to each stage
//   o_ce         : per-stage clock enable
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_chain #(
  parameter int NUM_STAGES = 4
) (
  input  wire logic [NUM_STAGES-1:0] i_valid,
  input  wire logic [NUM_STAGES-1:0] i_stall_req,
  input  wire logic                  i_sink_ready,
  input  wire logic [NUM_STAGES-1:0] i_flush,
  output logic      [NUM_STAGES-1:0] o_stall,
  output logic      [NUM_STAGES-1:0] o_ce
);

  logic [NUM_STAGES-1:0] w_stall;

  // Walk from the sink back to the source. A stage only forwards the
  // downstream stall when it actually holds data, so bubbles absorb stalls.
  always_comb begin
    w_stall                 = '0;
    w_stall[NUM_STAGES-1]   = i_stall_req[NUM_STAGES-1] |
                              (i_valid[NUM_STAGES-1] & ~i_sink_ready);
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      w_stall[i] = i_stall_req[i] | (i_valid[i] & w_stall[i+1]);
    end
  end

  assign o_stall = w_stall;
  // Flush takes precedence: a flushed stage never loads.
  assign o_ce    = ~w_stall & ~i_flush;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central stall/flush sequencer for a linear valid/ready pipeline.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   pif (slave)     : stage valid / stall request / sink ready in,
//                     per-stage stall and clock enable out
//   i_flush_req     : single-cycle flush request
//   i_flush_stage   : flush stages 0..i_flush_stage (clamped to all stages)
//   o_stage_flush   : per-stage flush, held FLUSH_CYCLES cycles
//   o_busy          : flush sequence in progress
//   o_stall_count   : saturating count of cycles with stage 0 stalled
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int SW           = 4
) (
  input  wire logic                   i_clk,
  input  wire logic                   i_rst,
  pipe_ctrl_if.slave                  pif,
  input  wire logic                   i_flush_req,
  input  wire logic [SW-1:0]          i_flush_stage,
  output logic      [NUM_STAGES-1:0]  o_stage_flush,
  output logic                        o_busy,
  output logic      [STALL_CNT_W-1:0] o_stall_count
);

  localparam logic [FLUSH_CNT_W-1:0] c_CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [NUM_STAGES-1:0]  r_mask;
  logic [NUM_STAGES-1:0]  w_mask_nxt;
  logic [FLUSH_CNT_W-1:0] r_cnt;
  logic [FLUSH_CNT_W-1:0] w_cnt_nxt;
  logic [NUM_STAGES-1:0]  w_new_mask;
  logic [STALL_CNT_W-1:0] r_stall_count;

  // Prefix mask 0..i_flush_stage; indices past the last stage naturally
  // select every stage, which gives the clamp for free.
  always_comb begin
    w_new_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_new_mask[i] = (32'(i) <= 32'(i_flush_stage));
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. A request in FLUSH, including the cycle the counter
  // hits zero, widens the mask and restarts the full flush duration.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_flush_req) begin
          w_state_nxt = S_FLUSH;
          w_mask_nxt  = w_new_mask;
          w_cnt_nxt   = c_CNT_LOAD;
        end
      end
      S_FLUSH: begin
        if (i_flush_req) begin
          w_mask_nxt = r_mask | w_new_mask;
          w_cnt_nxt  = c_CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_mask_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_stage_flush = '0;
    o_busy        = 1'b0;
    if (r_state == S_FLUSH) begin
      o_stage_flush = r_mask;
      o_busy        = 1'b1;
    end
  end

  pipe_stall_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_stall_chain (
    .i_valid      (pif.i_stage_valid),
    .i_stall_req  (pif.i_stage_stall_req),
    .i_sink_ready (pif.i_sink_ready),
    .i_flush      (o_stage_flush),
    .o_stall      (pif.o_stage_stall),
    .o_ce         (pif.o_stage_ce)
  );

  // Source-stall performance counter, saturating
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (pif.o_stage_stall[0] && (r_stall_count != STALL_CNT_MAX)) begin
      r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign o_stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl: directed literal checks plus
//            randomized traffic compared every cycle against a behavioural
//            model of the stall chain, flush sequencing and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int N  = 4;
  localparam int FC = 2;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req;
  logic [SW-1:0] flush_stage;
  logic [N-1:0]  flush;
  logic          busy;
  logic [15:0]   scount;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  pipe_ctrl_if #(.NUM_STAGES(N)) pif ();

  pipe_ctrl #(
    .NUM_STAGES   (N),
    .FLUSH_CYCLES (FC),
    .SW           (SW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .pif           (pif),
    .i_flush_req   (flush_req),
    .i_flush_stage (flush_stage),
    .o_stage_flush (flush),
    .o_busy        (busy),
    .o_stall_count (scount)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Stage i stalls if some stage j >= i requests a stall and every stage
  // from i up to j-1 holds data, or if all stages from i to the end hold
  // data and the sink is not ready.
  function automatic logic [N-1:0] ref_stall(input logic [N-1:0] v,
                                             input logic [N-1:0] r,
                                             input logic rdy);
    logic [N-1:0] s;
    bit ok;
    s = '0;
    for (int i = 0; i < N; i++) begin
      ok = 1'b1;
      for (int j = i; j < N; j++) begin
        if (ok && r[j]) s[i] = 1'b1;
        ok = ok && v[j];
      end
      if (ok && !rdy) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [N-1:0] ref_mask(input logic [SW-1:0] stg);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (i <= int'(stg)) m[i] = 1'b1;
    return m;
  endfunction

  int           m_rem;   // flush cycles still to show
  logic [N-1:0] m_mask;
  int           m_cnt;

  logic [N-1:0] exp_stall, exp_flush, exp_ce;
  logic         exp_busy;
  logic [15:0]  exp_cnt;

  assign exp_stall = ref_stall(pif.i_stage_valid, pif.i_stage_stall_req, pif.i_sink_ready);
  assign exp_flush = (rst || m_rem == 0) ? '0 : m_mask;
  assign exp_busy  = !rst && (m_rem > 0);
  assign exp_ce    = ~exp_stall & ~exp_flush;
  assign exp_cnt   = rst ? 16'd0 : 16'(m_cnt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_mask <= '0;
      m_cnt  <= 0;
    end else begin
      if (exp_stall[0] && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (flush_req) begin
        m_mask <= ((m_rem > 0) ? m_mask : '0) | ref_mask(flush_stage);
        m_rem  <= FC;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_mask <= '0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(pif.o_stage_stall), 32'(exp_stall));
      check("ce",    32'(pif.o_stage_ce),    32'(exp_ce));
      check("flush", 32'(flush),             32'(exp_flush));
      check("busy",  32'(busy),              32'(exp_busy));
      check("count", 32'(scount),            32'(exp_cnt));
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r, input logic rdy);
    pif.i_stage_valid     = v;
    pif.i_stage_stall_req = r;
    pif.i_sink_ready      = rdy;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    flush_req   = 1'b0;
    flush_stage = '0;
    drive('0, '0, 1'b1);
    chk_en      = 1'b1;

    @(negedge clk);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_flush", 32'(flush),  32'd0);
    check("rst_count", 32'(scount), 32'd0);
    next_cyc();
    rst = 1'b0;

    // Stall propagation with sink blocked, then released in the same cycle
    drive(4'b1111, 4'b0000, 1'b0);
    @(negedge clk); #1;
    check("t1_stall", 32'(pif.o_stage_stall), 32'b1111);
    check("t1_ce",    32'(pif.o_stage_ce),    32'b0000);
    drive(4'b1111, 4'b0000, 1'b1);
    #1;
    check("t1_stall_rel", 32'(pif.o_stage_stall), 32'b0000);
    check("t1_ce_rel",    32'(pif.o_stage_ce),    32'b1111);

    // Bubble collapse
    drive(4'b1011, 4'b0000, 1'b0);
    #1;
    check("t2_stall", 32'(pif.o_stage_stall), 32'b1000);
    check("t2_ce",    32'(pif.o_stage_ce),    32'b0111);

    // Internal stall at stage 1, counter steps by one per cycle
    drive(4'b1111, 4'b0010, 1'b1);
    #1;
    check("t3_stall", 32'(pif.o_stage_stall), 32'b0011);
    next_cyc();
    check("t3_cnt1", 32'(scount), 32'd1);
    next_cyc();
    check("t3_cnt2", 32'(scount), 32'd2);
    drive(4'b1111, 4'b0000, 1'b1);

    // Flush timing
    flush_req = 1'b1; flush_stage = 4'd1;
    next_cyc();
    flush_req = 1'b0;
    check("t4_flush1", 32'(flush), 32'b0011);
    check("t4_busy1",  32'(busy),  32'd1);
    check("t4_ce1",    32'(pif.o_stage_ce), 32'b1100);
    next_cyc();
    check("t4_flush2", 32'(flush), 32'b0011);
    next_cyc();
    check("t4_flush3", 32'(flush), 32'b0000);
    check("t4_busy3",  32'(busy),  32'd0);

    // Extended flush and clamp
    flush_req = 1'b1; flush_stage = 4'd0;
    next_cyc();
    check("t5_flush_a", 32'(flush), 32'b0001);
    flush_stage = 4'd2;
    next_cyc();
    flush_req = 1'b0;
    check("t5_flush_b", 32'(flush), 32'b0111);
    next_cyc();
    check("t5_flush_c", 32'(flush), 32'b0111);
    next_cyc();
    check("t5_flush_d", 32'(flush), 32'b0000);
    flush_req = 1'b1; flush_stage = 4'd9;
    next_cyc();
    flush_req = 1'b0;
    check("t5_clamp", 32'(flush), 32'b1111);

    // Asynchronous reset mid-flush
    #2 rst = 1'b1;
    #1;
    check("t6_rst_flush", 32'(flush),  32'd0);
    check("t6_rst_busy",  32'(busy),   32'd0);
    check("t6_rst_count", 32'(scount), 32'd0);
    next_cyc();
    rst = 1'b0;
    next_cyc();
    check("t6_idle", 32'(busy), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(N'($urandom), N'(($urandom_range(0, 7) == 0) ? $urandom : 0),
            $urandom_range(0, 3) != 0);
      flush_req   = ($urandom_range(0, 9) == 0);
      flush_stage = SW'($urandom);
      rst         = ($urandom_range(0, 299) == 0);
      next_cyc();
    end
    rst = 1'b0;
    flush_req = 1'b0;

    // Saturation of the stall counter
    drive(4'b0000, 4'b0001, 1'b1);
    repeat (70000) @(posedge clk);
    #1;
    check("t7_sat", 32'(scount), 32'hFFFF);
    repeat (5) next_cyc();
    check("t7_sat_hold", 32'(scount), 32'hFFFF);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for a linear valid/ready pipeline of NUM_STAGES stages (stage 0 = source, e.g. the counter stage; stage NUM_STAGES-1 feeds the sink).
- Builds the backward stall chain from per-stage stall requests and sink readiness, and generates per-stage clock-enables.
- Runs a small FSM that holds multi-cycle flushes of a stage prefix.
- Keeps a saturating count of source-stall cycles for performance monitoring.

Parameters:
NUM_STAGES, 4, number of pipeline stages controlled (2..16)
FLUSH_CYCLES, 2, cycles o_stage_flush stays asserted per flush (1..15)
SW, 4, width of stage index, must satisfy 2**SW >= NUM_STAGES

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_stage_valid  in  NUM_STAGES  valid flag of each stage's output register
i_stage_stall_req  in  NUM_STAGES  internal stall condition of each stage
i_sink_ready  in  1  consumer after last stage can accept
i_flush_req  in  1  single-cycle flush request
i_flush_stage  in  SW  flush stages 0..i_flush_stage inclusive
o_stage_stall  out  NUM_STAGES  stall to each stage (used as !ready by the stage before it)
o_stage_ce  out  NUM_STAGES  per-stage enable
o_stage_flush  out  NUM_STAGES  per-stage flush
o_busy  out  1  flush sequence in progress
o_stall_count  out  16  saturating count of cycles with o_stage_stall[0]=1

Behaviour:
- Reset (i_rst=1, async): FSM=IDLE, flush mask=0, flush counter=0, o_stall_count=0.
  - o_stage_flush=0 and o_busy=0 immediately.
  - Stall/ce outputs remain combinational from inputs.
- Stall chain (combinational, zero latency):
  - stall[N-1] = stall_req[N-1] | (valid[N-1] & ~i_sink_ready).
  - stall[i] = stall_req[i] | (valid[i] & stall[i+1]) for i < N-1.
  - A stage holding no valid data never propagates a downstream stall (bubble collapse).
- o_stage_ce[i] = ~o_stage_stall[i] & ~o_stage_flush[i].
- Flush mask: bits 0..i_flush_stage set.
  - i_flush_stage >= NUM_STAGES is clamped to all stages.
- FSM states: IDLE, FLUSH.
  - IDLE + i_flush_req: next cycle FLUSH; mask registered; counter = FLUSH_CYCLES-1.
  - FLUSH: o_stage_flush = mask, o_busy=1; counter decrements each cycle. At 0 with no new request, return to IDLE and clear the mask.
  - FLUSH + new i_flush_req: mask |= new mask; counter reloads to FLUSH_CYCLES-1.
  - Latency: flush visible exactly 1 cycle after the request; lasts exactly FLUSH_CYCLES cycles when there is no re-request.
- Flush overrides stall: a flushed stage has ce=0 regardless of stall. o_stage_stall itself is still driven combinationally.
- o_stall_count increments on each clock with o_stage_stall[0]=1; saturates at 16'hFFFF (no wrap).
- Reset mid-flush: o_stage_flush drops in the same cycle reset asserts; after deassert, the FSM is IDLE.
- Request arriving in the same cycle the counter reaches 0: treated as a re-request, so FLUSH continues.

Decomposition:
- Shared package pipe_pkg: FSM state encoding (IDLE=1'b0, FLUSH=1'b1), STALL_CNT_W=16, STALL_CNT_MAX.
- One natural sub-module: pipe_stall_chain, the purely combinational stall/ce generator. The FSM and counter stay in pipe_ctrl.

Test Plan:
1. Stall propagation: N=4, all valid=1, i_sink_ready=0 -> o_stage_stall=4'b1111, o_stage_ce=0. Set ready=1 -> stall=0, ce=4'b1111 in the same cycle.
2. Bubble collapse: valid=4'b1011 (stage 2 empty), ready=0 -> stall=4'b1000. Stages 0,1 keep ce=1.
3. Internal stall: stall_req[1]=1, ready=1, all valid -> stall=4'b0011; o_stall_count increments by 1 per cycle.
4. Flush timing: pulse i_flush_req with i_flush_stage=1, FLUSH_CYCLES=2 -> o_stage_flush=4'b0011 on cycles t+1 and t+2, o_busy=1; at t+3 both return to 0.
5. Extended flush: in FLUSH with mask 4'b0001, request i_flush_stage=2 -> mask 4'b0111 for 2 further cycles. Also i_flush_stage=9 -> mask 4'b1111.
6. Reset and saturation: assert i_rst mid-flush -> o_stage_flush=0 asynchronously. Hold stall[0] for 70000 cycles -> o_stall_count=16'hFFFF and stays there.
